banked_sram_2p: RTL and testbench

BANKED_SRAM_2P -- requirements
Module: banked_sram_2p

---
 rtl/banked_sram_2p_pkg.sv | 17 +
 rtl/sram_bank_2p.sv | 36 +++
 rtl/banked_sram_2p.sv | 136 +++++++++++++
 tb/tb_banked_sram_2p.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/banked_sram_2p_pkg.sv
// Shared definitions for the banked two-port SRAM.
//   state_t      : controller state (INIT sweep / READY for traffic)
//   DEF_NBANKS   : default number of independently write-enabled banks
//   DEF_WIDTH    : default bits per bank word
//   DEF_DEPTH    : default words per bank
package banked_sram_2p_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int DEF_NBANKS = 8;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 128;

endpackage

// File: rtl/sram_bank_2p.sv
// One bank of the banked SRAM: WIDTH x DEPTH, one synchronous read port and
// one write port, no reset on the array so it maps onto block RAM.
// A same-address read and write return the old contents; the top level
// handles write-first forwarding.
//   clock  : sole clock
//   r_en   : read enable, r_data updates on the next edge, otherwise holds
//   r_addr : read address
//   r_data : registered read data
//   w_en   : write enable
//   w_addr : write address
//   w_data : write data
module sram_bank_2p #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             r_en,
  input  logic [AW-1:0]    r_addr,
  output logic [WIDTH-1:0] r_data,
  input  logic             w_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  always_ff @(posedge clock) begin
    if (r_en) r_data <= mem[r_addr];
  end

endmodule

// File: rtl/banked_sram_2p.sv
// Banked two-port SRAM with a zeroing sweep after reset or flush.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_INIT  | writing zero to every bank, one address per cycle; requests ignored
//   ST_READY | array initialised; reads, masked writes and flush accepted
//
// Ports:
//   clock, reset              : clock, asynchronous active-high reset
//   io_r_en/io_r_addr         : read request, data one cycle later
//   io_r_data/io_r_valid      : read data (bank i at [i*WIDTH +: WIDTH]), valid flag
//   io_w_en/io_w_addr         : write request
//   io_w_data/io_w_maskOH     : write data, per-bank write enable (any pattern)
//   io_flush                  : re-run the zeroing sweep
//   io_ready                  : high in ST_READY only
module banked_sram_2p
  import banked_sram_2p_pkg::*;
#(
  parameter int NBANKS = DEF_NBANKS,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_r_en,
  input  logic [AW-1:0]           io_r_addr,
  output logic [NBANKS*WIDTH-1:0] io_r_data,
  output logic                    io_r_valid,
  input  logic                    io_w_en,
  input  logic [AW-1:0]           io_w_addr,
  input  logic [NBANKS*WIDTH-1:0] io_w_data,
  input  logic [NBANKS-1:0]       io_w_maskOH,
  input  logic                    io_flush,
  output logic                    io_ready
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t                  state;
  logic [AW-1:0]           sweep;
  logic                    rd_seen;
  logic                    rd_acc;
  logic [NBANKS-1:0]       bank_we;
  logic [AW-1:0]           bank_waddr;
  logic [NBANKS*WIDTH-1:0] bank_wdata;
  logic [NBANKS*WIDTH-1:0] bank_rdata;
  logic [NBANKS*WIDTH-1:0] byp_data;
  logic [NBANKS-1:0]       byp_sel;

  assign rd_acc = (state == ST_READY) && io_r_en;

  // The sweep owns the write port while initialising.
  always_comb begin
    bank_we    = '0;
    bank_waddr = io_w_addr;
    bank_wdata = io_w_data;
    if (state == ST_INIT) begin
      bank_we    = '1;
      bank_waddr = sweep;
      bank_wdata = '0;
    end else if (io_w_en) begin
      bank_we = io_w_maskOH;
    end
  end

  for (genvar i = 0; i < NBANKS; i++) begin : g_bank
    sram_bank_2p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
      .clock  (clock),
      .r_en   (rd_acc),
      .r_addr (io_r_addr),
      .r_data (bank_rdata[i*WIDTH +: WIDTH]),
      .w_en   (bank_we[i]),
      .w_addr (bank_waddr),
      .w_data (bank_wdata[i*WIDTH +: WIDTH])
    );
  end

  // Write-first forwarding: remember, per bank, whether the accepted read
  // collided with a write to that bank. Only updated on accepted reads so
  // the output holds between reads.
  always_ff @(posedge clock) begin
    if (rd_acc) begin
      byp_sel  <= (io_w_en && (io_w_addr == io_r_addr)) ? io_w_maskOH : '0;
      byp_data <= io_w_data;
    end
  end

  // rd_seen hides the unreset bank output registers until the first read.
  always_comb begin
    io_r_data = '0;
    for (int i = 0; i < NBANKS; i++) begin
      if (rd_seen)
        io_r_data[i*WIDTH +: WIDTH] = byp_sel[i] ? byp_data[i*WIDTH +: WIDTH]
                                                 : bank_rdata[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      sweep      <= '0;
      io_ready   <= 1'b0;
      io_r_valid <= 1'b0;
      rd_seen    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          io_r_valid <= 1'b0;
          if (sweep == LAST_ADDR) begin
            state    <= ST_READY;
            sweep    <= '0;
            io_ready <= 1'b1;
          end else begin
            sweep <= sweep + AW'(1);
          end
        end
        ST_READY: begin
          io_r_valid <= io_r_en;
          if (io_r_en) rd_seen <= 1'b1;
          if (io_flush) begin
            state    <= ST_INIT;
            sweep    <= '0;
            io_ready <= 1'b0;
          end
        end
        default: begin
          state    <= ST_INIT;
          sweep    <= '0;
          io_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_banked_sram_2p.sv
// Self-checking bench for banked_sram_2p: directed scenarios plus random
// traffic, compared each cycle against a behavioural array model.
module tb_banked_sram_2p;

  localparam int NB    = 8;
  localparam int WIDTH = 32;
  localparam int DEPTH = 128;
  localparam int AW    = $clog2(DEPTH);
  localparam int TW    = NB * WIDTH;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_r_en = 1'b0;
  logic [AW-1:0] io_r_addr = '0;
  logic [TW-1:0] io_r_data;
  logic          io_r_valid;
  logic          io_w_en = 1'b0;
  logic [AW-1:0] io_w_addr = '0;
  logic [TW-1:0] io_w_data = '0;
  logic [NB-1:0] io_w_maskOH = '0;
  logic          io_flush = 1'b0;
  logic          io_ready;

  int total = 0;
  int bad   = 0;

  // behavioural model
  logic [WIDTH-1:0] mem [NB][DEPTH];
  bit               m_ready;
  int               m_init_left;
  logic             exp_valid;
  logic [TW-1:0]    exp_data;

  banked_sram_2p #(.NBANKS(NB), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_r_en     (io_r_en),
    .io_r_addr   (io_r_addr),
    .io_r_data   (io_r_data),
    .io_r_valid  (io_r_valid),
    .io_w_en     (io_w_en),
    .io_w_addr   (io_w_addr),
    .io_w_data   (io_w_data),
    .io_w_maskOH (io_w_maskOH),
    .io_flush    (io_flush),
    .io_ready    (io_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_enter_init();
    m_ready     = 1'b0;
    m_init_left = DEPTH;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) mem[b][a] = '0;
  endtask

  function automatic logic [TW-1:0] fill(input logic [WIDTH-1:0] v);
    logic [TW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  function automatic logic [TW-1:0] pat(input int a);
    logic [TW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*WIDTH +: WIDTH] = WIDTH'(32'h1000 + a * 16 + b);
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".ready"}, TW'(io_ready), TW'(m_ready));
    chk({tag, ".valid"}, TW'(io_r_valid), TW'(exp_valid));
    chk({tag, ".data"}, io_r_data, exp_data);
  endtask

  // One clock cycle: drive, clock, advance model, compare.
  task automatic step(input logic re, input logic [AW-1:0] ra, input logic we,
                      input logic [AW-1:0] wa, input logic [TW-1:0] wd,
                      input logic [NB-1:0] m, input logic fl);
    io_r_en = re; io_r_addr = ra; io_w_en = we; io_w_addr = wa;
    io_w_data = wd; io_w_maskOH = m; io_flush = fl;
    @(posedge clock);
    if (m_ready) begin
      if (we)
        for (int b = 0; b < NB; b++)
          if (m[b]) mem[b][wa] = wd[b*WIDTH +: WIDTH];
      exp_valid = re;
      if (re)
        for (int b = 0; b < NB; b++) exp_data[b*WIDTH +: WIDTH] = mem[b][ra];
      if (fl) model_enter_init();
    end else begin
      exp_valid = 1'b0;
      m_init_left--;
      if (m_init_left == 0) m_ready = 1'b1;
    end
    #1;
    check_outputs("step");
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rand_step(input int addr_hi, input int flush_pct);
    step(1'($urandom), AW'($urandom_range(0, addr_hi)), 1'($urandom),
         AW'($urandom_range(0, addr_hi)),
         {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
         NB'($urandom), 1'($urandom_range(0, 99) < flush_pct));
  endtask

  // Runs until io_ready rises; cnt = cycles taken. Traffic during INIT is random.
  task automatic wait_ready(input bit traffic, output int cnt);
    cnt = 0;
    while (io_ready !== 1'b1 && cnt < 400) begin
      if (traffic) rand_step(DEPTH - 1, 50);
      else idle();
      cnt++;
    end
  endtask

  task automatic do_reset();
    io_r_en = 1'b0; io_w_en = 1'b0; io_flush = 1'b0; io_w_maskOH = '0;
    reset = 1'b1;
    #1;
    model_enter_init();
    exp_valid = 1'b0;
    exp_data  = '0;
    check_outputs("reset");
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [TW-1:0] e;

    // reset then idle
    do_reset();
    wait_ready(1'b0, cnt);
    chk("init_cycles", TW'(cnt), TW'(DEPTH));
    step(1'b1, AW'(5), 1'b0, '0, '0, '0, 1'b0);
    chk("rd5_valid", TW'(io_r_valid), TW'(1));
    chk("rd5_zero", io_r_data, '0);

    // full-mask write then read next cycle
    for (int b = 0; b < NB; b++) e[b*WIDTH +: WIDTH] = WIDTH'(32'hA0 + b);
    step(1'b0, '0, 1'b1, AW'(3), e, 8'hFF, 1'b0);
    step(1'b1, AW'(3), 1'b0, '0, '0, '0, 1'b0);
    chk("wr3_data", io_r_data, e);
    idle();
    chk("hold_valid", TW'(io_r_valid), TW'(0));
    chk("hold_data", io_r_data, e);

    // write-first collision with partial mask
    step(1'b0, '0, 1'b1, AW'(7), fill(32'h11), 8'hFF, 1'b0);
    step(1'b1, AW'(7), 1'b1, AW'(7), fill(32'h22), 8'h05, 1'b0);
    for (int b = 0; b < NB; b++)
      e[b*WIDTH +: WIDTH] = (b == 0 || b == 2) ? WIDTH'(32'h22) : WIDTH'(32'h11);
    chk("wfirst7", io_r_data, e);

    // flush clears contents; traffic during INIT is ignored
    step(1'b0, '0, 1'b1, AW'(9), fill(32'h55), 8'hFF, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    wait_ready(1'b1, cnt);
    chk("flush_cycles", TW'(cnt), TW'(DEPTH));
    step(1'b1, AW'(9), 1'b0, '0, '0, '0, 1'b0);
    chk("flush_rd9", io_r_data, '0);

    // reset in the middle of a sweep
    step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    repeat (60) idle();
    do_reset();
    chk("midreset_data", io_r_data, '0);
    wait_ready(1'b0, cnt);
    chk("midreset_cycles", TW'(cnt), TW'(DEPTH));
    chk("midreset_data2", io_r_data, '0);

    // back-to-back reads with concurrent writes half the array away
    for (int a = 0; a < DEPTH; a++) step(1'b0, '0, 1'b1, AW'(a), pat(a), 8'hFF, 1'b0);
    cnt = 0;
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, AW'(k), 1'b1, AW'((k + 64) % DEPTH), pat((k + 64) % DEPTH), 8'hFF, 1'b0);
      if (io_r_valid !== 1'b1 || io_r_data !== pat(k)) cnt++;
    end
    chk("b2b_errors", TW'(cnt), TW'(0));

    // random traffic on a small address window to force collisions
    for (int i = 0; i < 600; i++) rand_step(7, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
